neuron_ctrl: RTL and testbench

Sequencer that drives the neuron ALU for one neuron per tick. On `start` it walks the axon/synapse vectors, accumulates weighted spikes into the membrane potential, applies leak, compares against threshold, and fires/resets. It owns the membrane potential register and issues every arithmetic operation through the external `alu` (op/a/b out, f in). It sits between the core's tick scheduler and the neuron's spike output.

---
 rtl/neuron_pkg.sv | 24 ++
 rtl/neuron_ctrl.sv | 130 +++++++++++++
 tb/tb_neuron_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types for the neuron datapath: ALU opcodes, controller states and the
// membrane potential width.
package neuron_pkg;
  localparam int V_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SLL = 3'd1,
    OP_SRA = 3'd2,
    OP_SUB = 3'd3,
    OP_XOR = 3'd4,
    OP_SRL = 3'd5,
    OP_OR  = 3'd6,
    OP_AND = 3'd7
  } alu_ops_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INTEG,
    ST_LEAK,
    ST_THRESH,
    ST_DONE
  } ctrl_state_t;
endpackage

// File: rtl/neuron_ctrl.sv
// Per-tick neuron sequencer: integrates weighted spikes, applies leak and
// threshold/fire through an external ALU, and owns the membrane potential.
module neuron_ctrl
  import neuron_pkg::*;
#(
  parameter int NUM_AXONS = 256,
  parameter int NUM_TYPES = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  output logic                                       ready,
  input  logic [NUM_AXONS-1:0]                       axon_spike,
  input  logic [NUM_AXONS-1:0]                       synapse_row,
  input  logic [NUM_AXONS*$clog2(NUM_TYPES)-1:0]     axon_type,
  input  logic [NUM_TYPES*V_WIDTH-1:0]               weight,
  input  logic signed [V_WIDTH-1:0]                  leak,
  input  logic signed [V_WIDTH-1:0]                  threshold,
  input  logic signed [V_WIDTH-1:0]                  reset_v,
  output alu_ops_t                                   alu_op,
  output logic [V_WIDTH-1:0]                         alu_a,
  output logic [V_WIDTH-1:0]                         alu_b,
  input  logic [V_WIDTH-1:0]                         alu_f,
  output logic                                       done,
  output logic                                       spike,
  output logic [V_WIDTH-1:0]                         v_out
);
  localparam int IW = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;
  localparam int TW = $clog2(NUM_TYPES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_AXONS - 1);

  ctrl_state_t          state_reg, state_next;
  logic [IW-1:0]        idx_reg, idx_next;
  logic [V_WIDTH-1:0]   v_reg, v_next;
  logic                 fire_reg, fire_next;
  logic [NUM_AXONS-1:0] spike_lat_reg, spike_lat_next;
  logic [NUM_AXONS-1:0] syn_lat_reg, syn_lat_next;

  logic [TW-1:0]        type_arr [NUM_AXONS];
  logic [V_WIDTH-1:0]   weight_arr [NUM_TYPES];

  // Unflatten the configuration buses so the datapath can index them directly.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_AXONS; gi++) begin : g_type
      assign type_arr[gi] = axon_type[gi*TW +: TW];
    end
    for (gi = 0; gi < NUM_TYPES; gi++) begin : g_weight
      assign weight_arr[gi] = weight[gi*V_WIDTH +: V_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      v_reg         <= '0;
      fire_reg      <= 1'b0;
      spike_lat_reg <= '0;
      syn_lat_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      v_reg         <= v_next;
      fire_reg      <= fire_next;
      spike_lat_reg <= spike_lat_next;
      syn_lat_reg   <= syn_lat_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    v_next         = v_reg;
    fire_next      = fire_reg;
    spike_lat_next = spike_lat_reg;
    syn_lat_next   = syn_lat_reg;
    alu_op         = OP_ADD;
    alu_a          = '0;
    alu_b          = '0;
    ready          = 1'b0;
    done           = 1'b0;
    spike          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          spike_lat_next = axon_spike;
          syn_lat_next   = synapse_row;
          idx_next       = '0;
          state_next     = ST_INTEG;
        end
      end
      ST_INTEG: begin
        // Inactive axons still cost a cycle so tick latency never varies.
        if (spike_lat_reg[idx_reg] & syn_lat_reg[idx_reg]) begin
          alu_a  = v_reg;
          alu_b  = weight_arr[type_arr[idx_reg]];
          v_next = alu_f;
        end
        if (idx_reg == LAST_IDX) state_next = ST_LEAK;
        else                     idx_next   = idx_reg + IW'(1);
      end
      ST_LEAK: begin
        alu_a      = v_reg;
        alu_b      = leak;
        v_next     = alu_f;
        state_next = ST_THRESH;
      end
      ST_THRESH: begin
        // Sign of the wrapped difference decides firing; no overflow correction.
        alu_op     = OP_SUB;
        alu_a      = v_reg;
        alu_b      = threshold;
        fire_next  = ~alu_f[V_WIDTH-1];
        if (~alu_f[V_WIDTH-1]) v_next = reset_v;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        spike      = fire_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign v_out = v_reg;
endmodule

// File: tb/tb_neuron_ctrl.sv
// Directed bench for neuron_ctrl with a small behavioural ALU attached.
module tb_neuron_ctrl;
  import neuron_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [3:0]  axon_spike = '0;
  logic [3:0]  synapse_row = '0;
  logic [7:0]  axon_type = 8'b11_10_01_00;
  logic [127:0] weight = '0;
  logic signed [31:0] leak = '0, threshold = '0, reset_v = '0;
  alu_ops_t    alu_op;
  logic [31:0] alu_a, alu_b, alu_f;
  logic        done, spike;
  logic [31:0] v_out;

  int vectors = 0;
  int miscompares = 0;

  neuron_ctrl #(.NUM_AXONS(4), .NUM_TYPES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .axon_spike(axon_spike), .synapse_row(synapse_row),
    .axon_type(axon_type), .weight(weight),
    .leak(leak), .threshold(threshold), .reset_v(reset_v),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .done(done), .spike(spike), .v_out(v_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      OP_ADD:  alu_f = alu_a + alu_b;
      OP_SUB:  alu_f = alu_a - alu_b;
      OP_SLL:  alu_f = alu_a << alu_b[4:0];
      OP_SRL:  alu_f = alu_a >> alu_b[4:0];
      OP_SRA:  alu_f = $signed(alu_a) >>> alu_b[4:0];
      OP_XOR:  alu_f = alu_a ^ alu_b;
      OP_OR:   alu_f = alu_a | alu_b;
      OP_AND:  alu_f = alu_a & alu_b;
      default: alu_f = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
      $display("vec %0d %s: got %0h", vectors, tag, got);
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  // Starts a tick, expects done in cycle 7 (six edges after acceptance).
  task automatic run_tick(input string tag, input bit poke, input logic exp_spike,
                          input logic [31:0] exp_v);
    int cyc;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check({tag, " ready_low"}, 32'(ready), 32'd0);
    cyc = 0;
    while (!done && cyc < 40) begin
      start = poke && (cyc == 1);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'd6);
    check({tag, " spike"}, 32'(spike), 32'(exp_spike));
    check({tag, " v_out"}, v_out, exp_v);
    @(posedge clk); #1;
    check({tag, " done_drop"}, 32'(done), 32'd0);
    check({tag, " ready_back"}, 32'(ready), 32'd1);
  endtask

  initial begin
    // 1: reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("idle ready", 32'(ready), 32'd1);
      check("idle v_out", v_out, 32'd0);
      check("idle done", 32'(done), 32'd0);
    end
    check("idle alu_op", 32'(alu_op), 32'(OP_ADD));
    check("idle alu_a", alu_a, 32'd0);
    check("idle spike", 32'(spike), 32'd0);

    // 2/3: 10+20+40-5 = 65 no fire; 65+70-5 = 130 fires, v -> reset_v = 0
    weight = {32'sd40, 32'sd30, 32'sd20, 32'sd10};
    axon_spike = 4'b1011; synapse_row = 4'b1111;
    leak = -32'sd5; threshold = 32'sd100; reset_v = 32'sd0;
    run_tick("tick1", 1'b0, 1'b0, 32'd65);
    run_tick("tick2", 1'b0, 1'b1, 32'd0);

    // 4: negative weight/leak: 0-50-1 = -51; then -102 vs -60 still below
    weight[31:0] = -32'sd50;
    axon_spike = 4'b0001; synapse_row = 4'b0001;
    leak = -32'sd1; threshold = 32'sd0;
    run_tick("neg1", 1'b0, 1'b0, 32'hFFFF_FFCD);
    threshold = -32'sd60;
    run_tick("neg2", 1'b0, 1'b0, 32'hFFFF_FF9A);

    // 5: climb to 0x7FFFFFF0 then add 0x20 -> wraps to 0x80000010
    pulse_rst();
    weight[31:0] = 32'h7FFF_FFF0; leak = 32'sd0; threshold = 32'sh7FFF_FFFF;
    run_tick("wrap1", 1'b0, 1'b0, 32'h7FFF_FFF0);
    weight[31:0] = 32'h0000_0020; threshold = 32'sd0;
    run_tick("wrap2", 1'b0, 1'b0, 32'h8000_0010);

    // 6a: start while busy is neither honoured nor queued; v = 10+30 = 40
    pulse_rst();
    weight = {32'sd40, 32'sd30, 32'sd20, 32'sd10};
    axon_spike = 4'b1111; synapse_row = 4'b0101; leak = 32'sd0; threshold = 32'sd100;
    run_tick("busy_start", 1'b1, 1'b0, 32'd40);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_queue ready", 32'(ready), 32'd1);
    end

    // 6b: rst at INTEG index 2 aborts the tick with no done
    synapse_row = 4'b1111;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_abort v_out", v_out, 32'd70);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("abort ready", 32'(ready), 32'd1);
    check("abort v_out", v_out, 32'd0);
    check("abort done", 32'(done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort no_done", 32'(done), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
